// File: rtl/fxp_pkg.sv
// fxp_pkg: shared definitions for S1.5.6 sign-magnitude fixed-point values.
//   FXP_WIDTH    - total word width (sign + 5 integer + 6 fraction bits)
//   FXP_FRAC     - number of fraction bits
//   FXP_SIGN_BIT - index of the sign bit
//   fxp_t        - one S1.5.6 word
//   canon_zero   - maps -0 (sign set, zero magnitude) onto +0
package fxp_pkg;

   localparam int FXP_WIDTH    = 12;
   localparam int FXP_FRAC     = 6;
   localparam int FXP_SIGN_BIT = 11;

   typedef logic [FXP_WIDTH-1:0] fxp_t;

   // A zero magnitude is always returned as +0 so that -0 and +0 compare equal.
   function automatic fxp_t canon_zero(input fxp_t v);
      fxp_t r;
      if (v[FXP_SIGN_BIT-1:0] == {(FXP_SIGN_BIT){1'b0}}) begin
         r = {FXP_WIDTH{1'b0}};
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/fxp_cmp_comb.sv
// fxp_cmp_comb: combinational sign-magnitude comparator.
// Operands must already be zero-canonicalised (no -0 on the inputs).
//   a, b   : operands, bit WIDTH-1 is the sign, the rest is magnitude
//   gt/lt/eq : a > b, a < b, a == b (exactly one is set)
//   max_v  : larger operand (a on equality)
//   min_v  : smaller operand (a on equality)
module fxp_cmp_comb #(
   parameter int WIDTH = 12
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq,
   output logic [WIDTH-1:0] max_v,
   output logic [WIDTH-1:0] min_v
);

   logic             sign_a_s;
   logic             sign_b_s;
   logic [WIDTH-2:0] mag_a_s;
   logic [WIDTH-2:0] mag_b_s;

   assign sign_a_s = a[WIDTH-1];
   assign sign_b_s = b[WIDTH-1];
   assign mag_a_s  = a[WIDTH-2:0];
   assign mag_b_s  = b[WIDTH-2:0];

   // Relational decode: sign decides first, then magnitude (reversed for negatives).
   always_comb begin
      gt = 1'b0;
      lt = 1'b0;
      eq = 1'b0;
      if (sign_a_s != sign_b_s) begin
         // Canonical inputs cannot both be zero here, so the positive one wins.
         gt = ~sign_a_s;
         lt = sign_a_s;
      end else if (mag_a_s == mag_b_s) begin
         eq = 1'b1;
      end else if (sign_a_s == 1'b0) begin
         gt = (mag_a_s > mag_b_s);
         lt = (mag_a_s < mag_b_s);
      end else begin
         gt = (mag_a_s < mag_b_s);
         lt = (mag_a_s > mag_b_s);
      end
   end

   // Operand select: a is reported as both max and min when the values are equal.
   always_comb begin
      max_v = a;
      min_v = b;
      if (lt) begin
         max_v = b;
         min_v = a;
      end else begin
         max_v = a;
         min_v = b;
      end
   end

endmodule

// File: rtl/fixed_point_comparator_s156.sv
// fixed_point_comparator_s156: registered comparator for S1.5.6 sign-magnitude
// values, one cycle of latency, full throughput.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : a/b valid this cycle
//   a, b       : operands (sign-magnitude)
//   out_valid  : result registers hold the compare of the last valid input
//   a_gt_b, a_lt_b, a_eq_b, a_gte_b, a_lte_b : relational flags
//   max_out, min_out : larger / smaller operand, with -0 reported as +0
// Flags and max/min hold their value while in_valid is low.
module fixed_point_comparator_s156
   import fxp_pkg::*;
#(
   parameter int WIDTH = FXP_WIDTH,
   parameter int FRAC  = FXP_FRAC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b,
   output logic             a_gte_b,
   output logic             a_lte_b,
   output logic [WIDTH-1:0] max_out,
   output logic [WIDTH-1:0] min_out
);

   // canon_zero works on the package word type, so the width must match it.
   if (WIDTH != FXP_WIDTH || FRAC >= WIDTH) begin : g_bad_params
      $error("fixed_point_comparator_s156: unsupported WIDTH/FRAC");
   end

   logic [WIDTH-1:0] a_c_s;
   logic [WIDTH-1:0] b_c_s;
   logic             gt_s;
   logic             lt_s;
   logic             eq_s;
   logic [WIDTH-1:0] max_s;
   logic [WIDTH-1:0] min_s;

   logic             out_valid_r;
   logic             gt_r;
   logic             lt_r;
   logic             eq_r;
   logic             gte_r;
   logic             lte_r;
   logic [WIDTH-1:0] max_r;
   logic [WIDTH-1:0] min_r;

   assign a_c_s = canon_zero(a);
   assign b_c_s = canon_zero(b);

   fxp_cmp_comb #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a     (a_c_s),
      .b     (b_c_s),
      .gt    (gt_s),
      .lt    (lt_s),
      .eq    (eq_s),
      .max_v (max_s),
      .min_v (min_s)
   );

   // Result registers: capture on valid input, hold otherwise, clear on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         gt_r        <= 1'b0;
         lt_r        <= 1'b0;
         eq_r        <= 1'b0;
         gte_r       <= 1'b0;
         lte_r       <= 1'b0;
         max_r       <= {WIDTH{1'b0}};
         min_r       <= {WIDTH{1'b0}};
      end else if (in_valid) begin
         out_valid_r <= 1'b1;
         gt_r        <= gt_s;
         lt_r        <= lt_s;
         eq_r        <= eq_s;
         gte_r       <= gt_s | eq_s;
         lte_r       <= lt_s | eq_s;
         max_r       <= max_s;
         min_r       <= min_s;
      end else begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign a_gt_b    = gt_r;
   assign a_lt_b    = lt_r;
   assign a_eq_b    = eq_r;
   assign a_gte_b   = gte_r;
   assign a_lte_b   = lte_r;
   assign max_out   = max_r;
   assign min_out   = min_r;

endmodule

// File: tb/tb_fixed_point_comparator_s156.sv
// Self-checking bench for fixed_point_comparator_s156.
module tb_fixed_point_comparator_s156;

   localparam int W = 12;

   // flags packed as {gt, lt, eq, gte, lte}
   localparam logic [4:0] F_EQ   = 5'b00111;
   localparam logic [4:0] F_GT   = 5'b10010;
   localparam logic [4:0] F_LT   = 5'b01001;
   localparam logic [4:0] F_NONE = 5'b00000;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   flags;
      logic [W-1:0] mx;
      logic [W-1:0] mn;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         a_gt_b, a_lt_b, a_eq_b, a_gte_b, a_lte_b;
   logic [W-1:0] max_out;
   logic [W-1:0] min_out;

   int n_tests;
   int n_fail;

   fixed_point_comparator_s156 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .a_gt_b    (a_gt_b),
      .a_lt_b    (a_lt_b),
      .a_eq_b    (a_eq_b),
      .a_gte_b   (a_gte_b),
      .a_lte_b   (a_lte_b),
      .max_out   (max_out),
      .min_out   (min_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] obs_flags();
      return {a_gt_b, a_lt_b, a_eq_b, a_gte_b, a_lte_b};
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 12'h040; b = 12'h020;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, obs_flags(), max_out, min_out} !== {1'b0, F_NONE, 12'h000, 12'h000}) begin
         n_fail++;
         $display("FAIL reset: got v=%b f=%b max=%h min=%h, want v=0 f=00000 max=000 min=000",
                  out_valid, obs_flags(), max_out, min_out);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_equality();
      vec_t v [4];
      v = '{'{12'h000, 12'h000, F_EQ, 12'h000, 12'h000},
            '{12'h040, 12'h040, F_EQ, 12'h040, 12'h040},
            '{12'h840, 12'h840, F_EQ, 12'h840, 12'h840},
            '{12'h800, 12'h000, F_EQ, 12'h000, 12'h000}};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); in_valid = 1'b1; a = v[i].a; b = v[i].b;
         @(posedge clk); #1;
         n_tests++;
         if ({out_valid, obs_flags(), max_out, min_out} !== {1'b1, v[i].flags, v[i].mx, v[i].mn}) begin
            n_fail++;
            $display("FAIL equality[%0d] a=%h b=%h: got v=%b f=%b max=%h min=%h, want v=1 f=%b max=%h min=%h",
                     i, v[i].a, v[i].b, out_valid, obs_flags(), max_out, min_out, v[i].flags, v[i].mx, v[i].mn);
         end
      end
      @(negedge clk); in_valid = 1'b0;
   endtask

   task automatic test_ordering();
      vec_t v [11];
      v = '{'{12'h040, 12'h020, F_GT, 12'h040, 12'h020},
            '{12'h020, 12'h040, F_LT, 12'h040, 12'h020},
            '{12'h840, 12'h880, F_GT, 12'h840, 12'h880},
            '{12'h880, 12'h840, F_LT, 12'h840, 12'h880},
            '{12'h010, 12'h810, F_GT, 12'h010, 12'h810},
            '{12'h040, 12'h840, F_GT, 12'h040, 12'h840},
            '{12'h000, 12'h010, F_LT, 12'h010, 12'h000},
            '{12'h000, 12'h810, F_GT, 12'h000, 12'h810},
            '{12'h810, 12'h800, F_LT, 12'h000, 12'h810},
            '{12'h010, 12'h0C0, F_LT, 12'h0C0, 12'h010},
            '{12'h810, 12'h8C0, F_GT, 12'h810, 12'h8C0}};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk); in_valid = 1'b1; a = v[i].a; b = v[i].b;
         @(posedge clk); #1;
         n_tests++;
         if ({out_valid, obs_flags(), max_out, min_out} !== {1'b1, v[i].flags, v[i].mx, v[i].mn}) begin
            n_fail++;
            $display("FAIL ordering[%0d] a=%h b=%h: got v=%b f=%b max=%h min=%h, want v=1 f=%b max=%h min=%h",
                     i, v[i].a, v[i].b, out_valid, obs_flags(), max_out, min_out, v[i].flags, v[i].mx, v[i].mn);
         end
      end
      @(negedge clk); in_valid = 1'b0;
   endtask

   task automatic test_hold();
      @(negedge clk); in_valid = 1'b1; a = 12'h040; b = 12'h020;
      @(negedge clk); in_valid = 1'b0; a = 12'h020; b = 12'h040;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, obs_flags(), max_out, min_out} !== {1'b0, F_GT, 12'h040, 12'h020}) begin
         n_fail++;
         $display("FAIL hold: got v=%b f=%b max=%h min=%h, want v=0 f=%b max=040 min=020",
                  out_valid, obs_flags(), max_out, min_out, F_GT);
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk); in_valid = 1'b1; a = 12'h0C0; b = 12'h010;
      @(negedge clk); rst = 1'b1; a = 12'h010; b = 12'h0C0;
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, obs_flags(), max_out, min_out} !== {1'b0, F_NONE, 12'h000, 12'h000}) begin
         n_fail++;
         $display("FAIL reset_midstream: got v=%b f=%b max=%h min=%h, want v=0 f=00000 max=000 min=000",
                  out_valid, obs_flags(), max_out, min_out);
      end
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      vec_t v [3];
      v = '{'{12'h8C0, 12'h0C0, F_LT, 12'h0C0, 12'h8C0},
            '{12'h001, 12'h000, F_GT, 12'h001, 12'h000},
            '{12'h7FF, 12'h7FF, F_EQ, 12'h7FF, 12'h7FF}};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_valid = 1'b1; a = v[i].a; b = v[i].b;
         @(posedge clk); #1;
         n_tests++;
         if ({out_valid, obs_flags(), max_out, min_out} !== {1'b1, v[i].flags, v[i].mx, v[i].mn}) begin
            n_fail++;
            $display("FAIL back_to_back[%0d] a=%h b=%h: got v=%b f=%b max=%h min=%h, want v=1 f=%b max=%h min=%h",
                     i, v[i].a, v[i].b, out_valid, obs_flags(), max_out, min_out, v[i].flags, v[i].mx, v[i].mn);
         end
      end
      @(negedge clk); in_valid = 1'b0;
   endtask

   task automatic test_random();
      int           va, vb;
      logic [W-1:0] ca, cb, emx, emn;
      logic [4:0]   ef;
      int           bad;
      bad = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a = W'($urandom_range(0, 4095));
         b = W'($urandom_range(0, 4095));
         if ((i % 16) == 0) a = {a[W-1], 11'h000};
         if ((i % 16) == 1) b = a;
         va = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
         vb = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
         ca = (va == 0) ? 12'h000 : a;
         cb = (vb == 0) ? 12'h000 : b;
         ef  = {va > vb, va < vb, va == vb, va >= vb, va <= vb};
         emx = (va < vb) ? cb : ca;
         emn = (va < vb) ? ca : cb;
         @(posedge clk); #1;
         n_tests++;
         if ({out_valid, obs_flags(), max_out, min_out} !== {1'b1, ef, emx, emn}
             || $countones({a_gt_b, a_lt_b, a_eq_b}) != 1) begin
            n_fail++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d] a=%h b=%h: got v=%b f=%b max=%h min=%h, want v=1 f=%b max=%h min=%h",
                        i, a, b, out_valid, obs_flags(), max_out, min_out, ef, emx, emn);
         end
      end
      @(negedge clk); in_valid = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; in_valid = 1'b0; a = 12'h000; b = 12'h000;
      test_reset();
      test_equality();
      test_ordering();
      test_hold();
      test_reset_midstream();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
